// File: rtl/score_pkg.sv
// Shared types and constants for the score tracker.
package score_pkg;

   // Round progress: menu, round in play, final score on show.
   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StHold
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam int unsigned MAX_SCORE = 99;

   // Two-digit packed BCD of a small integer.
   function automatic logic [7:0] to_bcd2(input int unsigned v);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   localparam logic [7:0] MaxScoreBcd = to_bcd2(MAX_SCORE);

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD incrementer, saturating at MAX_SCORE, with synchronous clear.
// The next value is exported so the owner can register it elsewhere in the same cycle.
module bcd2_counter
   import score_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output bcd_t tens_o,
   output bcd_t ones_o,
   output bcd_t tens_d_o,
   output bcd_t ones_d_o
);

   bcd_t tens_q, tens_d;
   bcd_t ones_q, ones_d;

   // Next count: clear wins, otherwise increment with decimal carry unless saturated.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (clear_i) begin
         tens_d = '0;
         ones_d = '0;
      end else if (inc_i && ({tens_q, ones_q} != MaxScoreBcd)) begin
         if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens_o   = tens_q;
   assign ones_o   = ones_q;
   assign tens_d_o = tens_d;
   assign ones_d_o = ones_d;

endmodule

// File: rtl/score_tracker.sv
// Game score tracker: counts ticks survived, keeps a high score, holds and blinks the
// final score after a round. Outputs are loaded from next-state values so a tick's
// effect is visible the clock after that tick, with no input-to-output path.
module score_tracker
   import score_pkg::*;
#(
   parameter int unsigned HOLD_TICKS  = 48,
   parameter int unsigned BLINK_TICKS = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic tick_i,
   input  logic start_i,
   input  logic death_i,
   input  logic win_i,
   input  logic clear_hi_i,
   output bcd_t ones_o,
   output bcd_t tens_o,
   output logic blank_o,
   output logic new_high_o,
   output logic round_over_o
);

   localparam int unsigned HoldW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_TICKS - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

   state_e state_q, state_d;

   logic [7:0]        high_q, high_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic [BlinkW-1:0] blink_q, blink_d;
   logic              blank_q, blank_d;
   logic              new_high_q, new_high_d;
   bcd_t              ones_q, ones_d;
   bcd_t              tens_q, tens_d;
   logic              round_over_q, round_over_d;

   logic       cnt_clear, cnt_inc;
   bcd_t       score_tens, score_ones;
   bcd_t       score_tens_d, score_ones_d;
   logic [7:0] score;
   logic [7:0] disp_d;

   bcd2_counter u_score (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (cnt_clear),
      .inc_i    (cnt_inc),
      .tens_o   (score_tens),
      .ones_o   (score_ones),
      .tens_d_o (score_tens_d),
      .ones_d_o (score_ones_d)
   );

   // Packed BCD orders the same as the decimal value, so it compares directly.
   assign score = {score_tens, score_ones};

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: moves only on a game tick; leaving the menu abandons the round.
   always_comb begin
      state_d = state_q;
      if (tick_i) begin
         unique case (state_q)
            StIdle: if (start_i) state_d = StRun;
            StRun: begin
               if (!start_i) begin
                  state_d = StIdle;
               end else if (death_i || win_i) begin
                  state_d = StHold;
               end
            end
            StHold: if (hold_q == HoldLast) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Datapath and output next values for the current state.
   always_comb begin
      high_d     = high_q;
      hold_d     = hold_q;
      blink_d    = blink_q;
      blank_d    = blank_q;
      new_high_d = new_high_q;
      cnt_clear  = 1'b0;
      cnt_inc    = 1'b0;
      if (tick_i) begin
         unique case (state_q)
            StIdle: begin
               if (clear_hi_i) high_d = '0;
            end
            StRun: begin
               if (!start_i) begin
                  cnt_clear = 1'b1;
               end else if (death_i || win_i) begin
                  // Death and win enter the same hold; only the score matters.
                  new_high_d = (score > high_q);
                  if (score > high_q) high_d = score;
                  hold_d  = '0;
                  blink_d = '0;
                  blank_d = 1'b0;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            StHold: begin
               if (hold_q == HoldLast) begin
                  cnt_clear  = 1'b1;
                  hold_d     = '0;
                  blink_d    = '0;
                  blank_d    = 1'b0;
                  new_high_d = 1'b0;
               end else begin
                  hold_d = hold_q + HoldW'(1);
                  if (new_high_q) begin
                     if (blink_q == BlinkLast) begin
                        blink_d = '0;
                        blank_d = ~blank_q;
                     end else begin
                        blink_d = blink_q + BlinkW'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
      // Menu shows the high score; a round in play or on hold shows its own score.
      disp_d       = (state_d == StIdle) ? high_d : {score_tens_d, score_ones_d};
      tens_d       = disp_d[7:4];
      ones_d       = disp_d[3:0];
      round_over_d = (state_d == StHold);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         high_q       <= '0;
         hold_q       <= '0;
         blink_q      <= '0;
         blank_q      <= 1'b0;
         new_high_q   <= 1'b0;
         ones_q       <= '0;
         tens_q       <= '0;
         round_over_q <= 1'b0;
      end else begin
         high_q       <= high_d;
         hold_q       <= hold_d;
         blink_q      <= blink_d;
         blank_q      <= blank_d;
         new_high_q   <= new_high_d;
         ones_q       <= ones_d;
         tens_q       <= tens_d;
         round_over_q <= round_over_d;
      end
   end

   assign ones_o       = ones_q;
   assign tens_o       = tens_q;
   assign blank_o      = blank_q;
   assign new_high_o   = new_high_q;
   assign round_over_o = round_over_q;

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: behavioural model plus literal scenario checks.
module tb_score_tracker;

   localparam int unsigned HOLD  = 48;
   localparam int unsigned BLINK = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       death = 1'b0;
   logic       win = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] ones, tens;
   logic       blank, new_high, round_over;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   score_tracker #(
      .HOLD_TICKS  (HOLD),
      .BLINK_TICKS (BLINK)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tick_i       (tick),
      .start_i      (start),
      .death_i      (death),
      .win_i        (win),
      .clear_hi_i   (clr),
      .ones_o       (ones),
      .tens_o       (tens),
      .blank_o      (blank),
      .new_high_o   (new_high),
      .round_over_o (round_over)
   );

   always #5 clk = ~clk;

   // Model: mode 0 menu, 1 playing, 2 showing the final score.
   int m_mode, m_score, m_high, m_held;
   bit m_nh;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode = 0; m_score = 0; m_high = 0; m_held = 0; m_nh = 0;
      end else if (tick) begin
         if (m_mode == 0) begin
            if (clr) m_high = 0;
            if (start) m_mode = 1;
         end else if (m_mode == 1) begin
            if (!start) begin
               m_mode = 0; m_score = 0;
            end else if (death || win) begin
               m_nh = (m_score > m_high);
               if (m_nh) m_high = m_score;
               m_mode = 2; m_held = 0;
            end else begin
               m_score = (m_score >= 99) ? 99 : m_score + 1;
            end
         end else begin
            m_held++;
            if (m_held == HOLD) begin
               m_mode = 0; m_score = 0; m_nh = 0; m_held = 0;
            end
         end
      end
   end

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
      end
   endtask

   // Every cycle, shortly after the edge, the DUT must agree with the model.
   always @(posedge clk) begin
      #1;
      if (chk_en && !reset) begin
         check("disp", {tens, ones}, bcd((m_mode == 0) ? m_high : m_score));
         check("blank", 8'(blank),
               8'(m_mode == 2 && m_nh && ((m_held / BLINK) % 2 == 1)));
         check("new_high", 8'(new_high), 8'(m_mode == 2 && m_nh));
         check("round_over", 8'(round_over), 8'(m_mode == 2));
      end
   end

   task automatic lit(input string name, input int t, input int o, input bit b,
                      input bit n, input bit r);
      check({name, ".tens"}, 8'(tens), 8'(t));
      check({name, ".ones"}, 8'(ones), 8'(o));
      check({name, ".blank"}, 8'(blank), 8'(b));
      check({name, ".new_high"}, 8'(new_high), 8'(n));
      check({name, ".round_over"}, 8'(round_over), 8'(r));
   endtask

   task automatic do_tick(input bit s, input bit d, input bit w, input bit c);
      @(negedge clk);
      start = s; death = d; win = w; clr = c; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic run_ticks(input int n, input bit s, input bit d, input bit w, input bit c);
      for (int i = 0; i < n; i++) do_tick(s, d, w, c);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      lit("reset", 0, 0, 0, 0, 0);
      reset = 1'b0;
      chk_en = 1'b1;

      // Count up, then abandon the round.
      do_tick(1, 0, 0, 0);
      lit("s1_enter", 0, 0, 0, 0, 0);
      run_ticks(12, 1, 0, 0, 0);
      lit("s1_twelve", 1, 2, 0, 0, 0);
      do_tick(0, 0, 0, 0);
      lit("s1_abandon", 0, 0, 0, 0, 0);

      // Saturation.
      do_tick(1, 0, 0, 0);
      run_ticks(105, 1, 0, 0, 0);
      lit("s2_sat", 9, 9, 0, 0, 0);
      do_tick(0, 0, 0, 0);
      lit("s2_abandon", 0, 0, 0, 0, 0);

      // New high score with blinking.
      do_tick(1, 0, 0, 0);
      run_ticks(23, 1, 0, 0, 0);
      do_tick(1, 1, 0, 0);
      lit("s3_hold", 2, 3, 0, 1, 1);
      run_ticks(5, 1, 0, 0, 0);
      lit("s3_blink_off5", 2, 3, 0, 1, 1);
      do_tick(1, 0, 0, 0);
      lit("s3_blink_on", 2, 3, 1, 1, 1);
      run_ticks(6, 1, 0, 0, 0);
      lit("s3_blink_off", 2, 3, 0, 1, 1);
      run_ticks(35, 1, 0, 0, 0);
      lit("s3_last_hold", 2, 3, 1, 1, 1);
      do_tick(1, 0, 0, 0);
      lit("s3_idle", 2, 3, 0, 0, 0);

      // Lower score does not beat the high score.
      do_tick(1, 0, 0, 0);
      run_ticks(10, 1, 0, 0, 0);
      do_tick(1, 0, 1, 0);
      lit("s4_hold", 1, 0, 0, 0, 1);
      run_ticks(HOLD, 1, 0, 0, 0);
      lit("s4_idle", 2, 3, 0, 0, 0);

      // Clear high, then death and win together.
      do_tick(0, 0, 0, 1);
      lit("s5_clear", 0, 0, 0, 0, 0);
      do_tick(1, 0, 0, 0);
      run_ticks(5, 1, 0, 0, 0);
      do_tick(1, 1, 1, 0);
      lit("s5_hold", 0, 5, 0, 1, 1);
      run_ticks(HOLD, 1, 0, 0, 0);
      lit("s5_idle", 0, 5, 0, 0, 0);

      // Randomised play, with input noise between ticks.
      for (int k = 0; k < 2500; k++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start = 1'($urandom); death = 1'($urandom); win = 1'($urandom);
            clr = 1'($urandom);
         end
         do_tick($urandom_range(0, 15) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
      end

      // Async reset mid-hold.
      run_ticks(HOLD + 2, 0, 0, 0, 0);
      do_tick(0, 0, 0, 1);
      do_tick(1, 0, 0, 0);
      run_ticks(40, 1, 0, 0, 0);
      do_tick(1, 1, 0, 0);
      lit("s6_hold", 4, 0, 0, 1, 1);
      run_ticks(3, 1, 0, 0, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 lit("s6_async", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      lit("s6_after", 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
